// File: rtl/atm_pkg.sv
// Shared ATM definitions: widths, banknote denominations, note index encoding
// and the cash-dispenser state encoding.
package atm_pkg;

  localparam int unsigned AMT_W_DEF      = 11;
  localparam int unsigned CNT_W_DEF      = 8;
  localparam int unsigned INIT_NOTES_DEF = 8;
  localparam int unsigned NUM_DENOM      = 4;
  localparam int unsigned IDX_W          = 2;

  typedef enum logic [IDX_W-1:0] {
    NOTE_200 = 2'd0,
    NOTE_100 = 2'd1,
    NOTE_50  = 2'd2,
    NOTE_10  = 2'd3
  } note_idx_t;

  typedef enum logic [2:0] {
    DISP_IDLE     = 3'd0,
    DISP_PLAN     = 3'd1,
    DISP_DISPENSE = 3'd2,
    DISP_FINISH   = 3'd3,
    DISP_FAIL     = 3'd4
  } disp_state_t;

  // Face value of a note index, largest first so the plan is greedy.
  function automatic logic [AMT_W_DEF-1:0] denom_value(input logic [IDX_W-1:0] idx);
    case (idx)
      2'd0:    denom_value = AMT_W_DEF'(200);
      2'd1:    denom_value = AMT_W_DEF'(100);
      2'd2:    denom_value = AMT_W_DEF'(50);
      default: denom_value = AMT_W_DEF'(10);
    endcase
  endfunction

endpackage

// File: rtl/atm_cash_dispenser_if.sv
// Controller/mechanism side of the cash dispenser: request, status and note handshake.
interface atm_cash_dispenser_if #(
  parameter int unsigned AMT_W = atm_pkg::AMT_W_DEF
);
  logic             req;
  logic [AMT_W-1:0] amount;
  logic             refill;
  logic             busy;
  logic             done;
  logic             err;
  logic             note_valid;
  logic [1:0]       note_denom;
  logic             note_ready;
  logic             empty;

  modport master (
    output req, amount, refill, note_ready,
    input  busy, done, err, note_valid, note_denom, empty
  );

  modport slave (
    input  req, amount, refill, note_ready,
    output busy, done, err, note_valid, note_denom, empty
  );
endinterface

// File: rtl/atm_cash_dispenser.sv
// Greedy banknote planner and one-note-at-a-time dispenser with per-denomination
// inventory tracking.
module atm_cash_dispenser
  import atm_pkg::*;
#(
  parameter int unsigned AMT_W      = AMT_W_DEF,
  parameter int unsigned CNT_W      = CNT_W_DEF,
  parameter int unsigned INIT_NOTES = INIT_NOTES_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  atm_cash_dispenser_if.slave  bus
);

  disp_state_t                  state_q, state_d;
  logic [AMT_W-1:0]             rem_q, rem_d;
  logic [IDX_W-1:0]             idx_q, idx_d;
  logic [NUM_DENOM-1:0][CNT_W-1:0] plan_q, plan_d;
  logic [NUM_DENOM-1:0][CNT_W-1:0] inv_q, inv_d;
  logic                         busy_q, busy_d;
  logic                         done_q, done_d;
  logic                         err_q, err_d;
  logic                         note_valid_q, note_valid_d;
  logic [IDX_W-1:0]             note_denom_q, note_denom_d;

  logic [AMT_W-1:0]             denom_c;
  logic                         handshake_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= DISP_IDLE;
      rem_q        <= '0;
      idx_q        <= '0;
      plan_q       <= '0;
      inv_q        <= {NUM_DENOM{CNT_W'(INIT_NOTES)}};
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      note_valid_q <= 1'b0;
      note_denom_q <= '0;
    end else begin
      state_q      <= state_d;
      rem_q        <= rem_d;
      idx_q        <= idx_d;
      plan_q       <= plan_d;
      inv_q        <= inv_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
      note_valid_q <= note_valid_d;
      note_denom_q <= note_denom_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    idx_d       = idx_q;
    plan_d      = plan_q;
    inv_d       = inv_q;
    denom_c     = AMT_W'(denom_value(idx_q));
    handshake_c = note_valid_q & bus.note_ready;

    case (state_q)
      DISP_IDLE: begin
        if (bus.refill) begin
          inv_d = {NUM_DENOM{CNT_W'(INIT_NOTES)}};
        end else if (bus.req) begin
          rem_d   = bus.amount;
          plan_d  = '0;
          idx_d   = '0;
          state_d = (bus.amount == '0) ? DISP_FAIL : DISP_PLAN;
        end
      end
      // One greedy step per cycle; compare before subtract so rem never wraps.
      DISP_PLAN: begin
        if ((rem_q >= denom_c) && (plan_q[idx_q] < inv_q[idx_q])) begin
          rem_d         = rem_q - denom_c;
          plan_d[idx_q] = CNT_W'(plan_q[idx_q] + CNT_W'(1));
        end else if (idx_q != IDX_W'(NUM_DENOM - 1)) begin
          idx_d = IDX_W'(idx_q + IDX_W'(1));
        end else if (rem_q == '0) begin
          idx_d   = '0;
          state_d = DISP_DISPENSE;
        end else begin
          state_d = DISP_FAIL;
        end
      end
      DISP_DISPENSE: begin
        if (plan_q[idx_q] == '0) begin
          idx_d = IDX_W'(idx_q + IDX_W'(1));
        end else if (handshake_c) begin
          plan_d[idx_q] = CNT_W'(plan_q[idx_q] - CNT_W'(1));
          inv_d[idx_q]  = CNT_W'(inv_q[idx_q] - CNT_W'(1));
          if (plan_d == '0) state_d = DISP_FINISH;
        end
      end
      DISP_FINISH: state_d = DISP_IDLE;
      DISP_FAIL:   state_d = DISP_IDLE;
      default:     state_d = DISP_IDLE;
    endcase

    // Outputs are registered from the next-state view so they line up with state_q.
    busy_d       = (state_d != DISP_IDLE);
    done_d       = (state_d == DISP_FINISH);
    err_d        = (state_d == DISP_FAIL);
    note_valid_d = (state_d == DISP_DISPENSE) && (plan_d[idx_d] != '0);
    note_denom_d = note_valid_d ? idx_d : '0;
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.err        = err_q;
  assign bus.note_valid = note_valid_q;
  assign bus.note_denom = note_denom_q;
  assign bus.empty      = (inv_q == '0);

endmodule

// File: tb/tb_atm_cash_dispenser.sv
// Directed bench for atm_cash_dispenser: a table of withdrawals with expected
// note counts and inventory, plus hand sequences for refill/req collision and reset.
module tb_atm_cash_dispenser;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  atm_cash_dispenser_if #(.AMT_W(11)) bus();

  atm_cash_dispenser #(.AMT_W(11), .CNT_W(8), .INIT_NOTES(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic            rf;
    logic [10:0]     amt;
    logic [7:0]      stall;
    logic            br;
    logic            e;
    logic [3:0][7:0] cnt;
    logic [3:0][7:0] inv;
  } vec_t;

  localparam int NV = 12;
  vec_t vecs [NV];

  function automatic vec_t mk(input bit rf, input int amt, input int stall, input bit br,
                              input bit e, input int c0, input int c1, input int c2,
                              input int c3, input int i0, input int i1, input int i2,
                              input int i3);
    vec_t v;
    v.rf = rf; v.amt = 11'(amt); v.stall = 8'(stall); v.br = br; v.e = e;
    v.cnt[0] = 8'(c0); v.cnt[1] = 8'(c1); v.cnt[2] = 8'(c2); v.cnt[3] = 8'(c3);
    v.inv[0] = 8'(i0); v.inv[1] = 8'(i1); v.inv[2] = 8'(i2); v.inv[3] = 8'(i3);
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_inv(input string tag, input int i0, input int i1, input int i2, input int i3);
    check({tag, " inv0"}, int'(dut.inv_q[0]), i0);
    check({tag, " inv1"}, int'(dut.inv_q[1]), i1);
    check({tag, " inv2"}, int'(dut.inv_q[2]), i2);
    check({tag, " inv3"}, int'(dut.inv_q[3]), i3);
  endtask

  // Issue one request, act as the mechanism, and compare the outcome with v.
  task automatic run_txn(input vec_t v, input string tag);
    int  cnt [4];
    int  last;
    bit  fin;
    bit  got_err;
    int  stall_left;
    int  hold_denom;
    int  hold_inv;
    for (int i = 0; i < 4; i++) cnt[i] = 0;
    last = 0; fin = 1'b0; got_err = 1'b0; stall_left = int'(v.stall);
    hold_denom = 0; hold_inv = 0;
    @(negedge clk);
    if (v.rf) begin
      bus.refill = 1'b1;
      @(negedge clk);
      bus.refill = 1'b0;
    end
    bus.note_ready = (stall_left == 0);
    bus.req    = 1'b1;
    bus.amount = v.amt;
    @(negedge clk);
    bus.req = 1'b0;
    check({tag, " busy_accept"}, int'(bus.busy), 1);
    for (int it = 0; it < 600 && !fin; it++) begin
      if (bus.done || bus.err) begin
        fin     = 1'b1;
        got_err = bus.err;
      end else begin
        bus.req = v.br && (it == 3);
        if (v.br && it == 3) bus.amount = 11'd50;
        if (bus.note_valid && stall_left > 0) begin
          if (stall_left == int'(v.stall)) begin
            hold_denom = int'(bus.note_denom);
            hold_inv   = int'(dut.inv_q[bus.note_denom]);
          end else begin
            check({tag, " stall_valid"}, int'(bus.note_valid), 1);
            check({tag, " stall_denom"}, int'(bus.note_denom), hold_denom);
            check({tag, " stall_busy"}, int'(bus.busy), 1);
            check({tag, " stall_inv"}, int'(dut.inv_q[hold_denom]), hold_inv);
          end
          stall_left--;
          bus.note_ready = 1'b0;
        end else begin
          bus.note_ready = 1'b1;
          if (bus.note_valid) begin
            check({tag, " order"}, int'(int'(bus.note_denom) >= last), 1);
            last = int'(bus.note_denom);
            cnt[bus.note_denom]++;
          end
        end
        @(negedge clk);
      end
    end
    bus.req = 1'b0;
    if (!fin) check({tag, " timeout"}, 0, 1);
    check({tag, " err"}, int'(got_err), int'(v.e));
    check({tag, " busy_at_pulse"}, int'(bus.busy), 1);
    for (int i = 0; i < 4; i++) check({tag, " notes"}, cnt[i], int'(v.cnt[i]));
    @(negedge clk);
    bus.note_ready = 1'b0;
    check({tag, " busy_after"}, int'(bus.busy), 0);
    check({tag, " pulse_len"}, int'(bus.done | bus.err), 0);
    check_inv(tag, int'(v.inv[0]), int'(v.inv[1]), int'(v.inv[2]), int'(v.inv[3]));
    check({tag, " empty"}, int'(bus.empty), int'(v.inv == '0));
  endtask

  initial begin
    int n;
    checks = 0; errors = 0;
    rst_n = 1'b0;
    bus.req = 1'b0; bus.amount = '0; bus.refill = 1'b0; bus.note_ready = 1'b0;

    vecs[0]  = mk(0,  380, 0, 0, 0, 1, 1, 1, 3, 7, 7, 7, 5);
    vecs[1]  = mk(0,  105, 0, 0, 1, 0, 0, 0, 0, 7, 7, 7, 5);
    vecs[2]  = mk(0,    0, 0, 0, 1, 0, 0, 0, 0, 7, 7, 7, 5);
    vecs[3]  = mk(1, 2040, 0, 0, 0, 8, 4, 0, 4, 0, 4, 8, 4);
    vecs[4]  = mk(0, 2040, 0, 0, 1, 0, 0, 0, 0, 0, 4, 8, 4);
    vecs[5]  = mk(0,  840, 0, 0, 0, 0, 4, 8, 4, 0, 0, 0, 0);
    vecs[6]  = mk(0,   10, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[7]  = mk(1,  380, 5, 0, 0, 1, 1, 1, 3, 7, 7, 7, 5);
    vecs[8]  = mk(1,  380, 0, 1, 0, 1, 1, 1, 3, 7, 7, 7, 5);
    vecs[9]  = mk(0,   50, 0, 0, 0, 0, 0, 1, 0, 7, 7, 6, 5);
    vecs[10] = mk(0,   30, 0, 0, 0, 0, 0, 0, 3, 7, 7, 6, 2);
    vecs[11] = mk(0,   40, 0, 0, 1, 0, 0, 0, 0, 7, 7, 6, 2);

    repeat (3) @(negedge clk);
    check("rst busy", int'(bus.busy), 0);
    check("rst done", int'(bus.done), 0);
    check("rst err", int'(bus.err), 0);
    check("rst valid", int'(bus.note_valid), 0);
    check("rst denom", int'(bus.note_denom), 0);
    check("rst empty", int'(bus.empty), 0);
    check_inv("rst", 8, 8, 8, 8);
    rst_n = 1'b1;

    for (int k = 0; k < NV; k++) run_txn(vecs[k], $sformatf("vec%0d", k));

    // refill wins over a simultaneous req
    @(negedge clk);
    bus.refill = 1'b1; bus.req = 1'b1; bus.amount = 11'd50;
    @(negedge clk);
    bus.refill = 1'b0; bus.req = 1'b0;
    check("collide busy", int'(bus.busy), 0);
    check_inv("collide", 8, 8, 8, 8);
    @(negedge clk);
    check("collide busy2", int'(bus.busy), 0);
    check("collide valid", int'(bus.note_valid), 0);

    // reset mid-dispense after two delivered notes
    bus.note_ready = 1'b1; bus.req = 1'b1; bus.amount = 11'd380;
    @(negedge clk);
    bus.req = 1'b0;
    n = 0;
    for (int it = 0; it < 300 && n < 2; it++) begin
      if (bus.note_valid) n++;
      @(negedge clk);
    end
    check("rstmid notes", n, 2);
    check_inv("rstmid pre", 7, 7, 8, 8);
    #2 rst_n = 1'b0;
    #1;
    check("rstmid busy", int'(bus.busy), 0);
    check("rstmid done", int'(bus.done), 0);
    check("rstmid err", int'(bus.err), 0);
    check("rstmid valid", int'(bus.note_valid), 0);
    check("rstmid denom", int'(bus.note_denom), 0);
    check_inv("rstmid", 8, 8, 8, 8);
    bus.note_ready = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("rstmid nopulse", int'(bus.done | bus.err), 0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    check("rstmid idle", int'(bus.done | bus.err | bus.busy), 0);
    run_txn(mk(0, 50, 0, 0, 0, 0, 0, 1, 0, 8, 8, 7, 8), "post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
